// File: rtl/mips_lsu.sv
// Load/store unit between the MIPS core and a byte-lane data memory.
// Optional access timeout is enabled by defining LSU_TIMEOUT_EN.
module mips_lsu #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned LANES   = 4,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [1:0]           req_size,
   input  logic                 req_signed,
   input  logic [ADDR_W-1:0]    req_addr,
   input  logic [8*LANES-1:0]   req_wdata,
   output logic                 resp_valid,
   output logic [8*LANES-1:0]   resp_rdata,
   output logic                 resp_fault,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic [8*LANES-1:0]   mem_data_in,
   output logic [LANES-1:0]     mem_byte_en,
   output logic                 mem_read_en,
   output logic                 mem_write_en,
   input  logic                 mem_ready,
   input  logic [8*LANES-1:0]   mem_data_out
);

   localparam int unsigned DW = 8 * LANES;
   localparam int unsigned LB = $clog2(LANES);

   if (LANES < 2 || (1 << LB) != LANES) begin : g_lanes_chk
      $error("LANES must be a power of two >= 2");
   end
   if (TIMEOUT < 1) begin : g_timeout_chk
      $error("TIMEOUT must be >= 1");
   end

   typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

   state_e              state_q;
   logic                resp_valid_q, resp_fault_q;
   logic [DW-1:0]       resp_rdata_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [DW-1:0]       mem_data_in_q;
   logic [LANES-1:0]    mem_byte_en_q;
   logic                mem_read_en_q, mem_write_en_q;
   logic [1:0]          size_q;
   logic [LB-1:0]       off_q;
   logic                sgn_q;

   logic                size_ok, align_ok;
   logic [ADDR_W-1:0]   amask;
   logic [LB-1:0]       off_req;
   logic [LANES-1:0]    be_req;
   logic [DW-1:0]       din_req;
   logic [DW-1:0]       shifted, ld_data;
   logic                ld_sign;
   int unsigned         nbits;

   assign off_req  = req_addr[LB-1:0];
   assign size_ok  = 32'(req_size) <= LB;
   assign amask    = (ADDR_W'(1) << req_size) - ADDR_W'(1);
   assign align_ok = (req_addr & amask) == '0;

   // Lane enables and store data replicated by the access width.
   always_comb begin
      be_req  = '0;
      din_req = '0;
      for (int i = 0; i < int'(LANES); i++) begin
         if (i >= int'(off_req) && i < int'(off_req) + (1 << req_size)) be_req[i] = 1'b1;
         din_req[8*i +: 8] = req_wdata[8*(i % (1 << req_size)) +: 8];
      end
   end

   // Right-justify the selected bytes and extend from the top selected bit.
   always_comb begin
      shifted = mem_data_out >> {off_q, 3'b000};
      nbits   = 32'd8 << size_q;
      ld_sign = 1'b0;
      ld_data = '0;
      for (int b = 0; b < int'(DW); b++) begin
         if (b == int'(nbits) - 1) ld_sign = shifted[b];
      end
      for (int b = 0; b < int'(DW); b++) begin
         ld_data[b] = (b < int'(nbits)) ? shifted[b] : (sgn_q & ld_sign);
      end
   end

`ifdef LSU_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= StIdle;
         resp_valid_q   <= 1'b0;
         resp_fault_q   <= 1'b0;
         resp_rdata_q   <= '0;
         mem_addr_q     <= '0;
         mem_data_in_q  <= '0;
         mem_byte_en_q  <= '0;
         mem_read_en_q  <= 1'b0;
         mem_write_en_q <= 1'b0;
         size_q         <= '0;
         off_q          <= '0;
         sgn_q          <= 1'b0;
`ifdef LSU_TIMEOUT_EN
         cnt_q          <= '0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               resp_valid_q <= 1'b0;
               if (req_valid) begin
                  if (!size_ok || !align_ok) begin
                     state_q      <= StResp;
                     resp_valid_q <= 1'b1;
                     resp_fault_q <= 1'b1;
                     resp_rdata_q <= '0;
                  end else begin
                     state_q        <= StAccess;
                     mem_addr_q     <= {req_addr[ADDR_W-1:LB], {LB{1'b0}}};
                     mem_byte_en_q  <= be_req;
                     mem_data_in_q  <= din_req;
                     mem_read_en_q  <= ~req_we;
                     mem_write_en_q <= req_we;
                     size_q         <= req_size;
                     off_q          <= off_req;
                     sgn_q          <= req_signed;
`ifdef LSU_TIMEOUT_EN
                     cnt_q          <= '0;
`endif
                  end
               end
            end
            StAccess: begin
               if (mem_ready) begin
                  state_q        <= StResp;
                  resp_valid_q   <= 1'b1;
                  resp_fault_q   <= 1'b0;
                  resp_rdata_q   <= mem_write_en_q ? '0 : ld_data;
                  mem_read_en_q  <= 1'b0;
                  mem_write_en_q <= 1'b0;
                  mem_byte_en_q  <= '0;
               end
`ifdef LSU_TIMEOUT_EN
               else if (cnt_q == CW'(TIMEOUT - 1)) begin
                  state_q        <= StResp;
                  resp_valid_q   <= 1'b1;
                  resp_fault_q   <= 1'b1;
                  resp_rdata_q   <= '0;
                  mem_read_en_q  <= 1'b0;
                  mem_write_en_q <= 1'b0;
                  mem_byte_en_q  <= '0;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
`endif
            end
            StResp: begin
               resp_valid_q <= 1'b0;
               state_q      <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign req_ready    = (state_q == StIdle);
   assign resp_valid   = resp_valid_q;
   assign resp_fault   = resp_fault_q;
   assign resp_rdata   = resp_rdata_q;
   assign mem_addr     = mem_addr_q;
   assign mem_data_in  = mem_data_in_q;
   assign mem_byte_en  = mem_byte_en_q;
   assign mem_read_en  = mem_read_en_q;
   assign mem_write_en = mem_write_en_q;

endmodule

// File: tb/tb_mips_lsu.sv
// Directed bench for mips_lsu: vector table plus wait-state, timeout and reset sequences.
module tb_mips_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we, req_signed;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_fault;
   logic [31:0] resp_rdata, mem_addr, mem_data_in, mem_data_out;
   logic [3:0]  mem_byte_en;
   logic        mem_read_en, mem_write_en, mem_ready;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mips_lsu #(.ADDR_W(32), .LANES(4), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
      .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_byte_en(mem_byte_en),
      .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
      .mem_ready(mem_ready), .mem_data_out(mem_data_out)
   );

   typedef struct {
      string       name;
      logic        we;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rlanes;
      logic        fault;
      logic [31:0] eaddr;
      logic [3:0]  ebe;
      logic [31:0] edin;
      logic [31:0] erdata;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Present a request at a negedge; returns at the negedge of cycle 1.
   task automatic accept(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
      @(negedge clk);
      chk("ready before accept", {31'b0, req_ready}, 32'd1);
      req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
      req_addr = addr; req_wdata = wdata;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      accept(v.we, v.size, v.sgn, v.addr, v.wdata);
      if (v.fault) begin
         chk({v.name, " resp_valid c1"}, {31'b0, resp_valid}, 32'd1);
         chk({v.name, " fault"}, {31'b0, resp_fault}, 32'd1);
         chk({v.name, " rdata"}, resp_rdata, 32'd0);
         chk({v.name, " no mem en"}, {30'b0, mem_read_en, mem_write_en}, 32'd0);
         @(negedge clk);
         chk({v.name, " pulse end"}, {31'b0, resp_valid}, 32'd0);
         chk({v.name, " no mem en c2"}, {30'b0, mem_read_en, mem_write_en}, 32'd0);
      end else begin
         chk({v.name, " rd_en"}, {31'b0, mem_read_en}, {31'b0, ~v.we});
         chk({v.name, " wr_en"}, {31'b0, mem_write_en}, {31'b0, v.we});
         chk({v.name, " mem_addr"}, mem_addr, v.eaddr);
         chk({v.name, " byte_en"}, {28'b0, mem_byte_en}, {28'b0, v.ebe});
         chk({v.name, " no resp c1"}, {31'b0, resp_valid}, 32'd0);
         if (v.we) chk({v.name, " data_in"}, mem_data_in, v.edin);
         mem_ready = 1'b1; mem_data_out = v.rlanes;
         @(negedge clk);
         mem_ready = 1'b0; mem_data_out = 32'h0;
         chk({v.name, " resp_valid c2"}, {31'b0, resp_valid}, 32'd1);
         chk({v.name, " fault"}, {31'b0, resp_fault}, 32'd0);
         chk({v.name, " rdata"}, resp_rdata, v.erdata);
         chk({v.name, " en drop"}, {30'b0, mem_read_en, mem_write_en}, 32'd0);
         @(negedge clk);
         chk({v.name, " pulse end"}, {31'b0, resp_valid}, 32'd0);
         chk({v.name, " rdata held"}, resp_rdata, v.erdata);
      end
   endtask

   initial begin
      bit bad;
      //          name   we  sz  sg  addr   wdata         rlanes        flt eaddr  be    edin          erdata
      vecs[0]  = '{"LW",  0, 2, 0, 32'h100, 32'h0,        32'h44332211, 0, 32'h100, 4'hF, 32'h0,        32'h44332211};
      vecs[1]  = '{"LB",  0, 0, 1, 32'h103, 32'h0,        32'h80000000, 0, 32'h100, 4'h8, 32'h0,        32'hFFFFFF80};
      vecs[2]  = '{"LBU", 0, 0, 0, 32'h103, 32'h0,        32'h80000000, 0, 32'h100, 4'h8, 32'h0,        32'h00000080};
      vecs[3]  = '{"LH",  0, 1, 1, 32'h102, 32'h0,        32'h92340000, 0, 32'h100, 4'hC, 32'h0,        32'hFFFF9234};
      vecs[4]  = '{"SH",  1, 1, 0, 32'h102, 32'h0000BEEF, 32'hDEADBEEF, 0, 32'h100, 4'hC, 32'hBEEFBEEF, 32'h0};
      vecs[5]  = '{"LWmis", 0, 2, 0, 32'h102, 32'h0,      32'h0,        1, 32'h0,   4'h0, 32'h0,        32'h0};
      vecs[6]  = '{"SZ3", 0, 3, 0, 32'h100, 32'h0,        32'h0,        1, 32'h0,   4'h0, 32'h0,        32'h0};
      vecs[7]  = '{"LHU", 0, 1, 0, 32'h200, 32'h0,        32'h1234ABCD, 0, 32'h200, 4'h3, 32'h0,        32'h0000ABCD};
      vecs[8]  = '{"SB",  1, 0, 0, 32'h205, 32'hFFFFFF5A, 32'h0,        0, 32'h204, 4'h2, 32'h5A5A5A5A, 32'h0};
      vecs[9]  = '{"LBpos", 0, 0, 1, 32'h201, 32'h0,      32'h00007F00, 0, 32'h200, 4'h2, 32'h0,        32'h0000007F};
      vecs[10] = '{"LHmis", 0, 1, 0, 32'h101, 32'h0,      32'h0,        1, 32'h0,   4'h0, 32'h0,        32'h0};
      vecs[11] = '{"SW",  1, 2, 0, 32'h300, 32'hCAFEF00D, 32'h0,        0, 32'h300, 4'hF, 32'hCAFEF00D, 32'h0};

      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h0; mem_ready = 1'b0; mem_data_out = 32'h0;
      repeat (2) @(negedge clk);
      chk("reset req_ready", {31'b0, req_ready}, 32'd1);
      chk("reset resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("reset resp_fault", {31'b0, resp_fault}, 32'd0);
      chk("reset mem en", {30'b0, mem_read_en, mem_write_en}, 32'd0);
      chk("reset rdata", resp_rdata, 32'd0);
      chk("reset mem_addr", mem_addr, 32'd0);
      chk("reset byte_en", {28'b0, mem_byte_en}, 32'd0);
      chk("reset data_in", mem_data_in, 32'd0);
      rst = 1'b0;

      // mem_ready while idle must not produce a response
      @(negedge clk); mem_ready = 1'b1;
      @(negedge clk); mem_ready = 1'b0;
      chk("idle mem_ready resp", {31'b0, resp_valid}, 32'd0);
      chk("idle mem_ready ready", {31'b0, req_ready}, 32'd1);

      for (int i = 0; i < 12; i++) run_vec(vecs[i]);

      // three wait states
      accept(1'b0, 2'd2, 1'b0, 32'h400, 32'h0);
      for (int i = 0; i < 3; i++) begin
         chk("wait rd_en", {31'b0, mem_read_en}, 32'd1);
         chk("wait no resp", {31'b0, resp_valid}, 32'd0);
         chk("wait addr stable", mem_addr, 32'h400);
         @(negedge clk);
      end
      mem_ready = 1'b1; mem_data_out = 32'hA1B2C3D4;
      @(negedge clk);
      mem_ready = 1'b0; mem_data_out = 32'h0;
      chk("wait resp_valid", {31'b0, resp_valid}, 32'd1);
      chk("wait rdata", resp_rdata, 32'hA1B2C3D4);
      @(negedge clk);
      @(negedge clk);
      chk("wait rdata held", resp_rdata, 32'hA1B2C3D4);

      // memory never answers
      accept(1'b0, 2'd2, 1'b0, 32'h500, 32'h0);
      bad = 1'b0;
`ifdef LSU_TIMEOUT_EN
      for (int i = 1; i <= 8; i++) begin
         if (!mem_read_en || resp_valid) bad = 1'b1;
         @(negedge clk);
      end
      chk("timeout access cycles", {31'b0, bad}, 32'd0);
      chk("timeout resp_valid", {31'b0, resp_valid}, 32'd1);
      chk("timeout fault", {31'b0, resp_fault}, 32'd1);
      chk("timeout rdata", resp_rdata, 32'd0);
      chk("timeout en drop", {31'b0, mem_read_en}, 32'd0);
      @(negedge clk);
`else
      for (int i = 1; i < 100; i++) begin
         if (!mem_read_en || resp_valid) bad = 1'b1;
         @(negedge clk);
      end
      chk("long wait held", {31'b0, bad}, 32'd0);
      chk("long wait rd_en c100", {31'b0, mem_read_en}, 32'd1);
      mem_ready = 1'b1; mem_data_out = 32'h0BADF00D;
      @(negedge clk);
      mem_ready = 1'b0; mem_data_out = 32'h0;
      chk("long wait resp_valid", {31'b0, resp_valid}, 32'd1);
      chk("long wait fault", {31'b0, resp_fault}, 32'd0);
      chk("long wait rdata", resp_rdata, 32'h0BADF00D);
      @(negedge clk);
`endif

      // reset in the middle of an access
      accept(1'b0, 2'd2, 1'b0, 32'h600, 32'h0);
      chk("rst pre rd_en", {31'b0, mem_read_en}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst rd_en", {31'b0, mem_read_en}, 32'd0);
      chk("rst ready", {31'b0, req_ready}, 32'd1);
      chk("rst no resp", {31'b0, resp_valid}, 32'd0);
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      chk("rst no late resp", {31'b0, resp_valid}, 32'd0);
      run_vec(vecs[0]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
